dim_neuron_acc: RTL and testbench

Parametrised, multi-beat successor to the 8-input ternary-weight DIM neuron. Each beat accepts LANES signed activations and LANES ternary weights, reduces them with add/subtract/skip logic (no multipliers), and accumulates over NUM_BEATS beats to form one neuron output of LANES*NUM_BEATS inputs. The block sits between the activation/weight streamers and the next layer's input buffer. It provides valid/ready handshakes on both sides, output saturation, and an optional ReLU.

---
 rtl/dim_neuron_acc.sv | 138 +++++++++++++
 tb/tb_dim_neuron_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dim_neuron_acc.sv
// Multi-beat ternary-weight neuron accumulator.
// Add/subtract/skip lane reduction, saturating output, optional ReLU.
module dim_neuron_acc #(
  parameter int ACT_W     = 9,
  parameter int LANES     = 8,
  parameter int NUM_BEATS = 4,
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 12,
  parameter int RELU      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACT_W-1:0]   in_act,
  input  logic [LANES*2-1:0]       in_wt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_neuron,
  output logic                     out_sat
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BEATS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    S_ACC,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [OUT_W-1:0]   neuron_q, neuron_d;
  logic                      sat_q, sat_d;

  logic signed [ACC_W-1:0]   beat_sum;
  logic signed [ACC_W-1:0]   lane;
  logic signed [ACC_W-1:0]   total;
  logic signed [OUT_W-1:0]   res_val;
  logic                      res_sat;

  // Lane reduction: +1 adds, -1 subtracts, 0 and illegal 2'b10 skip.
  always_comb begin
    beat_sum = '0;
    lane     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = {{(ACC_W-ACT_W){in_act[i*ACT_W+ACT_W-1]}},
              in_act[i*ACT_W +: ACT_W]};
      case (in_wt[i*2 +: 2])
        2'b01:   beat_sum = beat_sum + lane;
        2'b11:   beat_sum = beat_sum - lane;
        default: beat_sum = beat_sum;
      endcase
    end
  end

  assign total = acc_q + beat_sum;

  // Saturate the final total to OUT_W, then optional ReLU.
  always_comb begin
    res_sat = 1'b0;
    res_val = total[OUT_W-1:0];
    if (total > SAT_MAX) begin
      res_val = SAT_MAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (total < SAT_MIN) begin
      res_val = SAT_MIN[OUT_W-1:0];
      res_sat = 1'b1;
    end
    if ((RELU != 0) && res_val[OUT_W-1]) begin
      res_val = '0;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neuron_d  = neuron_q;
    sat_d     = sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == LAST) begin
            neuron_d = res_val;
            sat_d    = res_sat;
            state_d  = S_HOLD;
          end else begin
            acc_d = total;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  // Accumulator, beat counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      neuron_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neuron_q <= neuron_d;
      sat_q    <= sat_d;
    end
  end

  assign out_neuron = neuron_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_dim_neuron_acc.sv
// Directed scoreboard bench for dim_neuron_acc.
// Runs a RELU=0 and a RELU=1 instance on shared stimulus.
module tb_dim_neuron_acc;

  localparam int ACT_W = 9;
  localparam int LANES = 8;
  localparam int NB    = 4;
  localparam int OUT_W = 12;

  typedef struct {
    int n;
    int s;
    int rn;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [LANES*ACT_W-1:0]  in_act;
  logic [LANES*2-1:0]      in_wt;
  logic                    out_ready;
  logic                    in_ready, out_valid, out_sat;
  logic signed [OUT_W-1:0] out_neuron;
  logic                    r_in_ready, r_out_valid, r_out_sat;
  logic signed [OUT_W-1:0] r_out_neuron;

  int   vecs = 0;
  int   errs = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dim_neuron_acc #(.RELU(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wt(in_wt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neuron(out_neuron), .out_sat(out_sat)
  );

  dim_neuron_acc #(.RELU(1)) u_relu (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r_in_ready),
    .in_act(in_act), .in_wt(in_wt),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .out_neuron(r_out_neuron), .out_sat(r_out_sat)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pack lanes, compute reference result, push to scoreboard.
  task automatic load(input int a[8], input logic [1:0] w[8]);
    int   sum, tot;
    exp_t e;
    sum = 0;
    for (int i = 0; i < LANES; i++) begin
      in_act[i*ACT_W +: ACT_W] = ACT_W'(a[i]);
      in_wt[i*2 +: 2] = w[i];
      if (w[i] == 2'b01) sum += a[i];
      else if (w[i] == 2'b11) sum -= a[i];
    end
    tot = sum * NB;
    if (tot > 2047) begin
      e.n = 2047; e.s = 1;
    end else if (tot < -2048) begin
      e.n = -2048; e.s = 1;
    end else begin
      e.n = tot; e.s = 0;
    end
    e.rn = (e.n < 0) ? 0 : e.n;
    sb.push_back(e);
  endtask

  task automatic send(input int bubbles, input string tag);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "_latency"}, int'(out_valid), (b == NB - 1) ? 1 : 0);
      for (int k = 0; k < bubbles; k++) @(negedge clk);
    end
  endtask

  task automatic take(input int hold, input string tag);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_valid_timeout"}, int'(out_valid), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({tag, "_neuron"}, int'($signed(out_neuron)), e.n);
      chk({tag, "_sat"}, int'(out_sat), e.s);
      chk({tag, "_relu_neuron"}, int'($signed(r_out_neuron)), e.rn);
      chk({tag, "_relu_sat"}, int'(r_out_sat), e.s);
      chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, int'(out_valid), 0);
    chk({tag, "_post_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int          a_base[8];
    logic [1:0]  w_base[8];
    int          a_v[8];
    logic [1:0]  w_v[8];

    a_base = '{0, 52, -41, 0, -12, 115, 95, 0};
    w_base = '{2'b01, 2'b11, 2'b00, 2'b00,
               2'b11, 2'b01, 2'b00, 2'b11};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_act = '0;
    in_wt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_neuron", int'($signed(out_neuron)), 0);
    chk("rst_sat", int'(out_sat), 0);

    load(a_base, w_base);
    send(0, "basic");
    take(0, "basic");

    for (int i = 0; i < 8; i++) begin
      a_v[i] = 255; w_v[i] = 2'b01;
    end
    load(a_v, w_v);
    send(0, "pos_sat");
    take(0, "pos_sat");

    for (int i = 0; i < 8; i++) a_v[i] = -256;
    load(a_v, w_v);
    send(0, "neg_sat");
    take(0, "neg_sat");

    load(a_base, w_base);
    send(2, "bubble");
    take(5, "bubble");
    load(a_base, w_base);
    send(0, "after_bp");
    take(0, "after_bp");

    for (int i = 0; i < 8; i++) begin
      in_act[i*ACT_W +: ACT_W] = 9'd127;
      in_wt[i*2 +: 2] = 2'b01;
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    load(a_base, w_base);
    send(0, "midrst");
    take(0, "midrst");

    w_v = w_base;
    w_v[0] = 2'b10;
    load(a_base, w_v);
    send(0, "illegal_w1");
    take(0, "illegal_w1");

    w_v = w_base;
    w_v[1] = 2'b10;
    load(a_base, w_v);
    send(1, "illegal_w2");
    take(0, "illegal_w2");

    a_v = '{-100, 37, 200, -5, 64, -128, 9, 1};
    w_v = '{2'b11, 2'b01, 2'b11, 2'b00,
            2'b01, 2'b01, 2'b10, 2'b11};
    load(a_v, w_v);
    send(0, "mixed_neg");
    take(1, "mixed_neg");

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
